// File: rtl/gray_share_ctrl.sv
// Shared Gray-to-binary converter: four requesters, round-robin arbitration,
// one binary bit resolved per cycle MSB first, one-cycle ack on completion.
module gray_share_ctrl #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] gray_in,
  output logic [3:0]     ack,
  output logic [W-1:0]   bin_out,
  output logic           busy,
  output logic [1:0]     grant_id
);

  localparam int unsigned KW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  g_q, g_d;
  logic [W-1:0]  b_q, b_d;
  logic [KW-1:0] k_q, k_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [3:0]    ack_q, ack_d;
  logic [W-1:0]  bin_q, bin_d;
  logic          busy_q, busy_d;
  logic [1:0]    gid_q, gid_d;

  logic [1:0]    win_c;
  logic [1:0]    scan_c;
  logic          found_c;
  logic [W-1:0]  win_code_c;
  logic [W:0]    b_ext_c;

  // Round-robin pick: first asserted req starting at ptr, then its code
  always_comb begin
    win_c      = ptr_q;
    scan_c     = ptr_q;
    found_c    = 1'b0;
    win_code_c = '0;
    for (int off = 0; off < 4; off++) begin
      scan_c = ptr_q + 2'(off);
      if (!found_c && req[scan_c]) begin
        win_c   = scan_c;
        found_c = 1'b1;
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (win_c == 2'(j)) win_code_c = gray_in[j*W +: W];
    end
  end

  // Zero above the MSB makes the top bit reduce to g[W-1] with the same XOR
  assign b_ext_c = {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    b_d     = b_q;
    k_d     = k_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    bin_d   = bin_q;
    busy_d  = busy_q;
    gid_d   = gid_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gid_d   = win_c;
          g_d     = win_code_c;
          k_d     = KW'(W - 1);
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < int'(W); i++) begin
          if (k_q == KW'(i)) b_d[i] = b_ext_c[i+1] ^ g_q[i];
        end
        k_d = k_q - KW'(1);
        if (k_q == '0) begin
          bin_d   = b_d;
          ack_d   = 4'(4'b0001 << gid_q);
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = gid_q + 2'd1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      b_q     <= '0;
      k_q     <= KW'(W - 1);
      ptr_q   <= '0;
      ack_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      b_q     <= b_d;
      k_q     <= k_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      gid_q   <= gid_d;
    end
  end

  assign ack      = ack_q;
  assign bin_out  = bin_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_gray_share_ctrl.sv
// Scoreboard bench for gray_share_ctrl (W=4): directed requests push expected
// (requester, result, ack cycle); a negedge monitor pops and compares on ack.
module tb_gray_share_ctrl;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] gray_in;
  logic [3:0]     ack;
  logic [W-1:0]   bin_out;
  logic           busy;
  logic [1:0]     grant_id;

  gray_share_ctrl #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gray_in  (gray_in),
    .ack      (ack),
    .bin_out  (bin_out),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [3:0] bin;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Hand-computed Gray -> binary for every 4-bit code
  logic [3:0] tbl [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                           4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && ack != 4'b0000) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=%b expected none (cycle %0d)", ack, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ack_onehot", int'(ack), int'(4'b0001 << e.id));
        check("grant_id", int'(grant_id), int'(e.id));
        check("bin_out", int'(bin_out), int'(e.bin));
        check("ack_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic [3:0] bin, input int at);
    exp_t e;
    e.id = id; e.bin = bin; e.cyc = at;
    q.push_back(e);
  endtask

  // Bounded wait for ack[i]; returns just after the edge ending the DONE cycle
  task automatic wait_ack(input int i);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (ack[i]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack[%0d] expected one within 40 cycles", i);
    end
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int base;
    req     = '0;
    gray_in = '0;
    rst     = 1'b1;
    step();
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_ack", int'(ack), 0);
    check("rst_bin", int'(bin_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_grant", int'(grant_id), 0);
    step();

    // Single request, req dropped right after grant; latency and busy width
    gray_in[3:0] = 4'b1011;
    req[0] = 1'b1;
    push(2'd0, 4'b1101, cyc + 5);
    step();
    req[0] = 1'b0;
    busy_cnt = 0;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("busy_cycles", busy_cnt, 5);
    step();

    // All 16 codes through requester 2
    for (int c = 0; c < 16; c++) begin
      gray_in[11:8] = 4'(c);
      req[2] = 1'b1;
      push(2'd2, tbl[c], cyc + 5);
      wait_ack(2);
      req[2] = 1'b0;
      step();
    end

    // Simultaneous requests after reset: order 0,1,2,3 spaced 6 cycles
    do_reset();
    gray_in = {4'b1101, 4'b1010, 4'b0111, 4'b0001};
    req = 4'b1111;
    base = cyc;
    push(2'd0, 4'd1, base + 5);
    push(2'd1, 4'd5, base + 11);
    push(2'd2, 4'd12, base + 17);
    push(2'd3, 4'd9, base + 23);
    for (int i = 0; i < 4; i++) begin
      wait_ack(i);
      req[i] = 1'b0;
    end
    step();

    // Fairness: req 0 and 3 held high; grants alternate 0,3,0,3
    gray_in = {4'b1100, 4'b0000, 4'b0000, 4'b0011};
    req = 4'b1001;
    base = cyc;
    push(2'd0, 4'd2, base + 5);
    push(2'd3, 4'd8, base + 11);
    push(2'd0, 4'd2, base + 17);
    push(2'd3, 4'd8, base + 23);
    wait_ack(0);
    wait_ack(3);
    wait_ack(0);
    wait_ack(3);
    req = 4'b0000;
    step();

    // Code changes after grant are ignored
    gray_in[7:4] = 4'b0110;
    req[1] = 1'b1;
    push(2'd1, 4'd4, cyc + 5);
    for (int n = 0; n < 5; n++) begin
      step();
      gray_in[7:4] = 4'($urandom);
    end
    step();
    req[1] = 1'b0;
    step();

    // Reset while k=1: no ack, outputs cleared, ptr back to 0
    gray_in[15:12] = 4'b1111;
    req[3] = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    req[3] = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_ack", int'(ack), 0);
    check("abort_bin", int'(bin_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_grant", int'(grant_id), 0);
    step();
    gray_in = {4'b0000, 4'b1110, 4'b0000, 4'b0101};
    req = 4'b0101;
    base = cyc;
    push(2'd0, 4'd6, base + 5);
    push(2'd2, 4'd11, base + 11);
    wait_ack(0);
    req[0] = 1'b0;
    wait_ack(2);
    req[2] = 1'b0;

    repeat (10) step();
    check("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_share_ctrl.md
# gray_share_ctrl

Shared Gray-to-binary conversion controller. Four requesters share one iterative converter that resolves one binary bit per cycle, MSB first. A round-robin arbiter grants the converter, the controller sequences the conversion, and the granted requester receives its result with a one-cycle acknowledge. The block sits between Gray-coded sources (position encoders, asynchronous-FIFO pointers) and binary consumers, so no source needs its own XOR chain.

## Interface
- W, default 4: code width in bits; legal range 2..16.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  4  per-requester request; level; held high until the matching ack.
- gray_in  in  4*W  requester i's Gray code in bits [i*W +: W]; sampled only at grant.
- ack  out  4  one-hot, one-cycle pulse; ack[i] high means bin_out holds requester i's result.
- bin_out  out  W  converted binary value; updated only on entry to DONE; holds otherwise.
- busy  out  1  high in CONV and DONE.
- grant_id  out  2  index of the requester currently or most recently granted.

Clock and reset are fixed: one clock, synchronous active-high reset.

## Operation
- States: IDLE, CONV, DONE.
- Registers: g (W, captured code), b (W, working result), k (bit index), ptr (2, round-robin start), plus the output registers.
- IDLE, no req: stay.
- IDLE, any req: the winner is the first set req[j] scanning j = ptr, ptr+1, ... mod 4. On that edge:
  - grant_id <= j
  - g <= gray_in[j*W +: W]
  - k <= W-1
  - state <= CONV
- CONV, each cycle:
  - At k = W-1, b[k] <= g[k]; at other k, b[k] <= b[k+1] ^ g[k].
  - k decrements.
  - After the k=0 bit, state <= DONE and bin_out <= the final result, including bit 0.
- DONE, one cycle:
  - ack[grant_id] = 1.
  - ptr <= grant_id + 1 (wraps 3 -> 0).
  - state <= IDLE.
- Arithmetic is pure XOR, with no carries. Bit i of the result is the XOR of g[W-1:i].
- Requester protocol:
  - gray_in changes after the grant edge are ignored.
  - req[i] must be low in the cycle after ack[i]. If it is still high, it is a new request and arbitrates normally.
- Boundary conditions:
  - Simultaneous requests: strictly round-robin, and no requester waits more than 3 other conversions.
  - req dropped mid-conversion: the conversion still completes and ack is still issued.
  - ptr wrap-around: after granting 3, the priority scan starts at 0.
  - Reset mid-operation: conversion aborts, no ack is issued, and all state returns to reset values.
- Reset values:
  - state = IDLE, ptr = 0, g = 0, b = 0, k = W-1.
  - Outputs: ack = 0, bin_out = 0, busy = 0, grant_id = 0.

## Timing
- Request seen in IDLE at cycle t:
  - CONV occupies cycles t+1 .. t+W.
  - DONE (ack high, bin_out valid) occurs in cycle t+W+1.
- Latency from the arbitration cycle to ack is W+1 cycles.
- Back-to-back throughput is one conversion per W+2 cycles, because each DONE is followed by at least one IDLE cycle.
- busy rises in cycle t+1 and falls after DONE, so it is low in the following IDLE cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from req or gray_in to any output.
- bin_out is stable from DONE until the next DONE.

## Test plan
- Single request, W=4, req[0] with gray_in[3:0]=4'b1011:
  - bin_out=4'b1101 with ack=4'b0001 exactly 5 cycles after the arbitration cycle.
  - busy is high for 5 cycles.
- Exhaustive, W=4: all 16 codes through requester 2. Each result equals the XOR-prefix model, e.g. 4'b1000 -> 4'b1111 and 4'b0000 -> 4'b0000.
- Simultaneous requests after reset, all four req high with distinct codes:
  - Acks arrive in order 0,1,2,3, spaced 6 cycles apart.
  - Each bin_out matches its own requester's code.
- Fairness: req[0] and req[3] re-raised every cycle after their ack. Grants alternate 3,0,3,0 after the first grant to 0, and ptr wraps correctly.
- Stability: gray_in[1] changed every cycle during its conversion. The result reflects only the value sampled at grant.
- Reset mid-CONV: rst asserted when k=1.
  - No ack is issued; bin_out=0, busy=0 and grant_id=0 on the next cycle.
  - A subsequent req[2]|req[0] is granted to 0 first.
